// File: rtl/memarb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and
// requester port identifiers.
package memarb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACC_CPU = 2'd1,
    S_ACC_DBG = 2'd2
  } state_e;

  // Port IDs double as indices into the two-bit eligibility vector.
  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/memarb_if.sv
// Bundle of requester handshakes and the external memory bus around memarb.
// Handshake: a requester raises req (with we/adr/wdata) and keeps it high until
// its ready pulses for one cycle; rdata is valid with ready and held afterwards.
interface memarb_if #(parameter int WIDTH = 8);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_adr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_ready;
  logic [WIDTH-1:0] cpu_rdata;

  logic             dbg_req;
  logic             dbg_we;
  logic [WIDTH-1:0] dbg_adr;
  logic [WIDTH-1:0] dbg_wdata;
  logic             dbg_ready;
  logic [WIDTH-1:0] dbg_rdata;

  logic             mem_write;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_ready, cpu_rdata,
    input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
    output dbg_ready, dbg_rdata,
    output mem_write, mem_adr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    output dbg_req, dbg_we, dbg_adr, dbg_wdata,
    input  dbg_ready, dbg_rdata,
    input  mem_write, mem_adr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/memarb_rr_pick2.sv
// Combinational two-way round-robin picker: a lone eligible port wins, and on
// a tie the port that was not granted last wins.
module rr_pick2
  import memarb_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |elig;
    grant_id    = P_CPU;
    // With only two ports, "the other one" is simply the inverted ID.
    if (elig[P_CPU] && elig[P_DBG]) begin
      grant_id = ~last;
    end else if (elig[P_DBG]) begin
      grant_id = P_DBG;
    end
  end

endmodule

// File: rtl/memarb.sv
// Round-robin arbiter sharing one byte-wide combinational-read memory between
// the CPU core and the debug/loader port, one access per grant.
module memarb
  import memarb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  memarb_if.slave  bus,
  output logic     busy,
  output state_e   fsm_state
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             dbg_ready_q, dbg_ready_d;
  logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

  logic [1:0]       elig;
  logic             grant_valid;
  logic             grant_id;

  // A port still holding req while it sees its own ready must not be re-served.
  always_comb begin
    elig        = 2'b00;
    elig[P_CPU] = bus.cpu_req && (state_q != S_ACC_CPU) && !cpu_ready_q;
    elig[P_DBG] = bus.dbg_req && (state_q != S_ACC_DBG) && !dbg_ready_q;
  end

  rr_pick2 u_pick (
    .elig        (elig),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = S_IDLE;
    last_d      = last_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    cpu_ready_d = 1'b0;
    dbg_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    unique case (state_q)
      S_ACC_CPU: begin
        cpu_ready_d = 1'b1;
        if (!we_q) cpu_rdata_d = bus.mem_rdata;
      end
      S_ACC_DBG: begin
        dbg_ready_d = 1'b1;
        if (!we_q) dbg_rdata_d = bus.mem_rdata;
      end
      default: ;
    endcase

    if (grant_valid) begin
      last_d = grant_id;
      if (grant_id == P_CPU) begin
        state_d = S_ACC_CPU;
        we_d    = bus.cpu_we;
        adr_d   = bus.cpu_adr;
        wdata_d = bus.cpu_wdata;
      end else begin
        state_d = S_ACC_DBG;
        we_d    = bus.dbg_we;
        adr_d   = bus.dbg_adr;
        wdata_d = bus.dbg_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= P_DBG;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ready_q <= dbg_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Address/data registers only change on a grant, so they hold through IDLE.
  assign bus.mem_adr   = adr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = (state_q != S_IDLE) && we_q && !reset;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dbg_ready = dbg_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign busy          = (state_q != S_IDLE);
  assign fsm_state     = state_q;

endmodule
